// File: rtl/igr_arb_csr_init.sv
// igr_arb_csr_init: AVMM initiator that programs the ingress-arbiter priority
// CSRs of the PTP bridge, one word per interface at BASE_ADDR+idx.
// Build option: define IGR_ARB_CSR_INIT_READBACK_EN to read back and compare
// each register after writing it (adds RD/WAIT states and a read timeout).
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for cfg_start; priorities latched on acceptance
//   S_WR   | avmm_write high for entry idx
//   S_RD   | avmm_read high for entry idx (readback build only)
//   S_WAIT | waiting for readdata_valid or timeout (readback build only)
//   S_DONE | cfg_done pulse; cfg_start ignored here
module igr_arb_csr_init #(
  parameter int unsigned BASE_ADDR  = 'h0,
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_INTF   = 4,
  parameter int          RD_TIMEOUT = 16,
  localparam int         IDX_W      = (NUM_INTF > 1) ? $clog2(NUM_INTF) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [NUM_INTF-1:0][3:0] cfg_priority,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     cfg_error,
  output logic [IDX_W-1:0]         cfg_err_idx,
  output logic [ADDR_WIDTH-1:0]    avmm_address,
  output logic                     avmm_read,
  output logic                     avmm_write,
  output logic [DATA_WIDTH-1:0]    avmm_writedata,
  output logic [DATA_WIDTH/8-1:0]  avmm_byteenable,
  input  logic [DATA_WIDTH-1:0]    avmm_readdata,
  input  logic                     avmm_readdata_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INTF - 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WAIT, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NUM_INTF-1:0][3:0] prio_q, prio_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]  be_q, be_d;
  logic                     write_q, write_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     adv;
  logic                     issue_wr;
  logic [IDX_W-1:0]         wr_idx;
  logic [3:0]               wr_prio;

`ifdef IGR_ARB_CSR_INIT_READBACK_EN
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  logic                     read_q, read_d;
  logic                     err_q, err_d;
  logic [IDX_W-1:0]         eidx_q, eidx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     fail;

  // Only the priority nibble of the read data takes part in the compare.
  logic unused_rdata;
  assign unused_rdata = ^avmm_readdata[DATA_WIDTH-1:4];
`else
  logic unused_rdata;
  assign unused_rdata = ^{avmm_readdata, avmm_readdata_valid};
`endif

  // Next-state and next-output computation; every output is registered.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    prio_d   = prio_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = '0;
    write_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    adv      = 1'b0;
    issue_wr = 1'b0;
    wr_idx   = idx_q;
    wr_prio  = prio_q[idx_q];
`ifdef IGR_ARB_CSR_INIT_READBACK_EN
    read_d   = 1'b0;
    err_d    = err_q;
    eidx_d   = eidx_q;
    cnt_d    = cnt_q;
    fail     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          prio_d   = cfg_priority;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_WR;
          issue_wr = 1'b1;
          wr_idx   = '0;
          wr_prio  = cfg_priority[0];
`ifdef IGR_ARB_CSR_INIT_READBACK_EN
          err_d    = 1'b0;
          eidx_d   = '0;
`endif
        end
      end
      S_WR: begin
`ifdef IGR_ARB_CSR_INIT_READBACK_EN
        read_d  = 1'b1;
        state_d = S_RD;
`else
        adv     = 1'b1;
`endif
      end
`ifdef IGR_ARB_CSR_INIT_READBACK_EN
      S_RD: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Valid data takes precedence over a timeout landing in the same cycle.
        if (avmm_readdata_valid) begin
          if (avmm_readdata[3:0] == prio_q[idx_q]) adv = 1'b1;
          else                                     fail = 1'b1;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          fail = 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (idx_q == LAST_IDX) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        idx_d    = idx_q + IDX_W'(1);
        wr_idx   = idx_d;
        wr_prio  = prio_q[idx_d];
        issue_wr = 1'b1;
        state_d  = S_WR;
      end
    end

`ifdef IGR_ARB_CSR_INIT_READBACK_EN
    if (fail) begin
      err_d   = 1'b1;
      eidx_d  = idx_q;
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
`endif

    // Address is held after the write so the readback reuses it.
    if (issue_wr) begin
      write_d = 1'b1;
      be_d    = '1;
      addr_d  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(wr_idx);
      wdata_d = DATA_WIDTH'(wr_prio);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      prio_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef IGR_ARB_CSR_INIT_READBACK_EN
      read_q  <= 1'b0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef IGR_ARB_CSR_INIT_READBACK_EN
      read_q  <= read_d;
      err_q   <= err_d;
      eidx_q  <= eidx_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign cfg_busy        = busy_q;
  assign cfg_done        = done_q;
  assign avmm_address    = addr_q;
  assign avmm_write      = write_q;
  assign avmm_writedata  = wdata_q;
  assign avmm_byteenable = be_q;
`ifdef IGR_ARB_CSR_INIT_READBACK_EN
  assign avmm_read       = read_q;
  assign cfg_error       = err_q;
  assign cfg_err_idx     = eidx_q;
`else
  assign avmm_read       = 1'b0;
  assign cfg_error       = 1'b0;
  assign cfg_err_idx     = '0;
`endif

endmodule

// File: tb/tb_igr_arb_csr_init.sv
// Testbench for igr_arb_csr_init: randomized priorities and responder latency,
// checked against a transaction/timing model derived from the sequence rules.
module tb_igr_arb_csr_init;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int NI   = 4;
  localparam int TO   = 16;
  localparam int IW   = 2;
  localparam int BASE = 0;
`ifdef IGR_ARB_CSR_INIT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_start;
  logic [NI-1:0][3:0] cfg_priority;
  logic               cfg_busy, cfg_done, cfg_error;
  logic [IW-1:0]      cfg_err_idx;
  logic [AW-1:0]      avmm_address;
  logic               avmm_read, avmm_write;
  logic [DW-1:0]      avmm_writedata;
  logic [DW/8-1:0]    avmm_byteenable;
  logic [DW-1:0]      avmm_readdata;
  logic               avmm_readdata_valid;

  igr_arb_csr_init #(
    .BASE_ADDR(BASE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_INTF(NI), .RD_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_priority(cfg_priority),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
    .cfg_err_idx(cfg_err_idx), .avmm_address(avmm_address), .avmm_read(avmm_read),
    .avmm_write(avmm_write), .avmm_writedata(avmm_writedata),
    .avmm_byteenable(avmm_byteenable), .avmm_readdata(avmm_readdata),
    .avmm_readdata_valid(avmm_readdata_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit wr;
    int addr;
    int data;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  int   exp_done, exp_eidx;
  bit   exp_err;
  int   obs_done, obs_done_cnt, obs_busy_bad, obs_proto_bad, obs_eidx;
  bit   obs_err;
  int   lat, bad_x;
  int   checks = 0;
  int   errors = 0;

  // Reference: cycle-accurate transaction list relative to the start cycle (0).
  task automatic build_exp(input logic [NI-1:0][3:0] pr, input int bad, input int silent);
    int t;
    exp_q.delete();
    exp_err  = 1'b0;
    exp_eidx = 0;
    t = 1;
    for (int k = 0; k < NI; k++) begin
      exp_q.push_back('{t, 1'b1, (BASE + k) % 256, int'(pr[k])});
      if (!RB) begin
        t = t + 1;
        continue;
      end
      exp_q.push_back('{t + 1, 1'b0, (BASE + k) % 256, 0});
      if (k == silent || lat + 1 > TO) begin
        exp_done = t + 2 + TO; exp_err = 1'b1; exp_eidx = k;
        return;
      end
      if (k == bad) begin
        exp_done = t + 3 + lat; exp_err = 1'b1; exp_eidx = k;
        return;
      end
      t = t + lat + 3;
    end
    exp_done = t;
  endtask

  function automatic int txn_diff();
    int d;
    d = (obs_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].wr != exp_q[i].wr ||
          obs_q[i].addr != exp_q[i].addr || obs_q[i].data != exp_q[i].data) d++;
    return d;
  endfunction

  // Drives one sequence, plays the AVMM responder and records observations.
  task automatic run_seq(input logic [NI-1:0][3:0] pr, input int bad, input int silent,
                         input bit repulse, input bit spurious, input int rst_at);
    int pend, rd_idx, c, tail;
    int mem[NI];
    obs_q.delete();
    obs_done = -1; obs_done_cnt = 0; obs_busy_bad = 0; obs_proto_bad = 0;
    obs_err = 1'b0; obs_eidx = 0;
    pend = 0; rd_idx = 0; tail = 0; c = 0;
    for (int k = 0; k < NI; k++) mem[k] = 0;
    @(negedge clk);
    cfg_priority        = pr;
    cfg_start           = 1'b1;
    avmm_readdata_valid = spurious;
    avmm_readdata       = $urandom;
    while (tail < 4 && c < 400) begin
      @(negedge clk);
      c++;
      cfg_start = (repulse && (c == 2 || c == exp_done)) ? 1'b1 : 1'b0;
      if (c == 1) cfg_priority = {$urandom} [15:0];
      if (avmm_write && avmm_read) obs_proto_bad++;
      if (avmm_write) begin
        obs_q.push_back('{c, 1'b1, int'(avmm_address), int'(avmm_writedata)});
        if (avmm_byteenable !== '1) obs_proto_bad++;
        if (int'(avmm_address) - BASE >= 0 && int'(avmm_address) - BASE < NI)
          mem[int'(avmm_address) - BASE] = int'(avmm_writedata[3:0]);
      end
      if (avmm_read) obs_q.push_back('{c, 1'b0, int'(avmm_address), 0});
      if (cfg_done === 1'b1) begin
        obs_done_cnt++;
        if (obs_done < 0) begin
          obs_done = c; obs_err = cfg_error; obs_eidx = int'(cfg_err_idx);
        end
      end
      if (cfg_busy !== ((c >= 1 && c < exp_done) ? 1'b1 : 1'b0)) obs_busy_bad++;
      if (obs_done >= 0) tail++;
      avmm_readdata_valid = 1'b0;
      avmm_readdata       = $urandom;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          avmm_readdata_valid = 1'b1;
          avmm_readdata[3:0]  = 4'(mem[rd_idx] ^ ((rd_idx == bad) ? bad_x : 0));
        end
      end
      if (avmm_read) begin
        rd_idx = int'(avmm_address) - BASE;
        if (rd_idx < 0 || rd_idx >= NI) rd_idx = 0;
        if (rd_idx != silent) pend = lat + 1;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        break;
      end
    end
    cfg_start           = 1'b0;
    avmm_readdata_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 1'b0; cfg_priority = '0;
    avmm_readdata_valid = 1'b0; avmm_readdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({avmm_write, avmm_read, cfg_busy, cfg_done, cfg_error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 00000",
               {avmm_write, avmm_read, cfg_busy, cfg_done, cfg_error});
    end
    checks++;
    if (avmm_address !== '0 || avmm_writedata !== '0) begin
      errors++;
      $display("FAIL reset_addr_data: got %h/%h want 0/0", avmm_address, avmm_writedata);
    end
    checks++;
    if (avmm_byteenable !== '0 || cfg_err_idx !== '0) begin
      errors++;
      $display("FAIL reset_be_eidx: got %h/%0d want 0/0", avmm_byteenable, cfg_err_idx);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_only();
    logic [NI-1:0][3:0] pr;
    pr = {4'd3, 4'd2, 4'd1, 4'd0};
    lat = 2;
    build_exp(pr, -1, -1);
    run_seq(pr, -1, -1, 1'b0, 1'b0, -1);
    checks++;
    if (txn_diff() !== 0) begin
      errors++;
      $display("FAIL basic_txns: %0d diffs, got %0d txns want %0d", txn_diff(), obs_q.size(), exp_q.size());
    end
    checks++;
    if (obs_done !== exp_done || obs_done_cnt !== 1) begin
      errors++;
      $display("FAIL basic_done: got cyc %0d x%0d want cyc %0d x1", obs_done, obs_done_cnt, exp_done);
    end
    checks++;
    if (obs_busy_bad !== 0 || obs_proto_bad !== 0) begin
      errors++;
      $display("FAIL basic_busy_proto: got %0d/%0d bad cycles want 0/0", obs_busy_bad, obs_proto_bad);
    end
    checks++;
    if (obs_err !== exp_err || obs_eidx !== exp_eidx) begin
      errors++;
      $display("FAIL basic_err: got %0d/%0d want %0d/%0d", obs_err, obs_eidx, exp_err, exp_eidx);
    end
  endtask

  // Random priorities and latencies, sequences issued back to back.
  task automatic test_back_to_back();
    logic [NI-1:0][3:0] pr;
    for (int n = 0; n < 10; n++) begin
      pr  = {$urandom} [15:0];
      lat = $urandom_range(0, 3);
      build_exp(pr, -1, -1);
      run_seq(pr, -1, -1, 1'b0, 1'b0, -1);
      checks++;
      if (txn_diff() !== 0 || obs_proto_bad !== 0) begin
        errors++;
        $display("FAIL b2b_txns[%0d]: %0d diffs, proto %0d, want 0/0", n, txn_diff(), obs_proto_bad);
      end
      checks++;
      if (obs_done !== exp_done || obs_done_cnt !== 1 || obs_busy_bad !== 0) begin
        errors++;
        $display("FAIL b2b_timing[%0d]: done %0d x%0d busy_bad %0d want %0d x1 0",
                 n, obs_done, obs_done_cnt, obs_busy_bad, exp_done);
      end
      checks++;
      if (obs_err !== exp_err) begin
        errors++;
        $display("FAIL b2b_err[%0d]: got %0d want %0d", n, obs_err, exp_err);
      end
    end
  endtask

  // Start while busy and in DONE, spurious valid in IDLE: none may matter.
  task automatic test_ignore_start();
    logic [NI-1:0][3:0] pr;
    pr  = {$urandom} [15:0];
    lat = 1;
    build_exp(pr, -1, -1);
    run_seq(pr, -1, -1, 1'b1, 1'b1, -1);
    checks++;
    if (txn_diff() !== 0) begin
      errors++;
      $display("FAIL ignore_txns: %0d diffs, got %0d txns want %0d", txn_diff(), obs_q.size(), exp_q.size());
    end
    checks++;
    if (obs_done !== exp_done || obs_done_cnt !== 1 || obs_busy_bad !== 0) begin
      errors++;
      $display("FAIL ignore_timing: done %0d x%0d busy_bad %0d want %0d x1 0",
               obs_done, obs_done_cnt, obs_busy_bad, exp_done);
    end
    checks++;
    if (obs_err !== exp_err) begin
      errors++;
      $display("FAIL ignore_err: got %0d want %0d", obs_err, exp_err);
    end
  endtask

`ifdef IGR_ARB_CSR_INIT_READBACK_EN
  task automatic test_mismatch();
    logic [NI-1:0][3:0] pr;
    pr    = {4'd3, 4'd1, 4'd7, 4'd9};
    lat   = 2;
    bad_x = 4;
    build_exp(pr, 2, -1);
    run_seq(pr, 2, -1, 1'b0, 1'b0, -1);
    checks++;
    if (txn_diff() !== 0) begin
      errors++;
      $display("FAIL mismatch_txns: %0d diffs, got %0d txns want %0d", txn_diff(), obs_q.size(), exp_q.size());
    end
    checks++;
    if (obs_err !== 1'b1 || obs_eidx !== 2 || obs_done !== exp_done) begin
      errors++;
      $display("FAIL mismatch_err: got err %0d idx %0d done %0d want 1 2 %0d", obs_err, obs_eidx, obs_done, exp_done);
    end
    checks++;
    if (obs_busy_bad !== 0 || obs_done_cnt !== 1) begin
      errors++;
      $display("FAIL mismatch_busy: busy_bad %0d done x%0d want 0 x1", obs_busy_bad, obs_done_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [NI-1:0][3:0] pr;
    pr  = {$urandom} [15:0];
    lat = 2;
    build_exp(pr, -1, 0);
    run_seq(pr, -1, 0, 1'b0, 1'b0, -1);
    checks++;
    if (txn_diff() !== 0) begin
      errors++;
      $display("FAIL timeout_txns: %0d diffs, got %0d txns want %0d", txn_diff(), obs_q.size(), exp_q.size());
    end
    checks++;
    if (obs_err !== 1'b1 || obs_eidx !== 0 || obs_done !== exp_done) begin
      errors++;
      $display("FAIL timeout_err: got err %0d idx %0d done %0d want 1 0 %0d", obs_err, obs_eidx, obs_done, exp_done);
    end
    // Valid exactly on the last allowed WAIT cycle: data must win.
    lat = TO - 1;
    build_exp(pr, -1, -1);
    run_seq(pr, -1, -1, 1'b0, 1'b0, -1);
    checks++;
    if (txn_diff() !== 0 || obs_err !== 1'b0 || obs_done !== exp_done) begin
      errors++;
      $display("FAIL edge_valid: diffs %0d err %0d done %0d want 0 0 %0d", txn_diff(), obs_err, obs_done, exp_done);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [NI-1:0][3:0] pr;
    pr  = {$urandom} [15:0];
    lat = 2;
    build_exp(pr, -1, -1);
    run_seq(pr, -1, -1, 1'b0, 1'b0, RB ? 1 + (lat + 3) + 2 : 2);
    @(negedge clk);
    checks++;
    if ({avmm_write, avmm_read, cfg_busy, cfg_done, cfg_error} !== 5'b0 ||
        avmm_address !== '0 || avmm_writedata !== '0 || avmm_byteenable !== '0 || cfg_err_idx !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b a=%h d=%h be=%h e=%0d want all 0",
               {avmm_write, avmm_read, cfg_busy, cfg_done, cfg_error},
               avmm_address, avmm_writedata, avmm_byteenable, cfg_err_idx);
    end
    rst = 1'b0;
    pr  = {$urandom} [15:0];
    build_exp(pr, -1, -1);
    run_seq(pr, -1, -1, 1'b0, 1'b0, -1);
    checks++;
    if (txn_diff() !== 0 || obs_done !== exp_done || obs_done_cnt !== 1 ||
        obs_busy_bad !== 0 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_rerun: diffs %0d done %0d x%0d busy_bad %0d err %0d want 0 %0d x1 0 0",
               txn_diff(), obs_done, obs_done_cnt, obs_busy_bad, obs_err, exp_done);
    end
  endtask

  initial begin
    lat   = 2;
    bad_x = 4;
    test_reset();
    test_write_only();
    test_back_to_back();
    test_ignore_start();
`ifdef IGR_ARB_CSR_INIT_READBACK_EN
    test_mismatch();
    test_timeout();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
